// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : wb_port_arbiter_if
// Description : Bundle of the two write requesters (P = pipeline writeback,
//               L = long-latency unit) and the shared register-file write
//               port.
//               master : requester side (drives requests, sees ready/port)
//               slave  : arbiter side (accepts requests, drives the port)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface wb_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  // Pipeline writeback requester
  logic              p_valid;
  logic [ADDR_W-1:0] p_rd;
  logic [DATA_W-1:0] p_data;
  logic              p_ready;

  // Long-latency unit requester
  logic              l_valid;
  logic [ADDR_W-1:0] l_rd;
  logic [DATA_W-1:0] l_data;
  logic              l_ready;

  // Pipeline freeze request
  logic              stall;

  // Register-file write port
  logic              rf_we;
  logic [ADDR_W-1:0] rw_out;
  logic [DATA_W-1:0] writedata_out;

  modport master (
    output p_valid, p_rd, p_data,
    output l_valid, l_rd, l_data,
    input  p_ready, l_ready, stall,
    input  rf_we, rw_out, writedata_out
  );

  modport slave (
    input  p_valid, p_rd, p_data,
    input  l_valid, l_rd, l_data,
    output p_ready, l_ready, stall,
    output rf_we, rw_out, writedata_out
  );

endinterface
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : wb_port_arbiter
// Description : Shares the single register-file write port between the
//               in-order pipeline writeback (P) and the long-latency
//               load/mul result unit (L). One grant per cycle; the winner is
//               registered onto rf_we/rw_out/writedata_out. P normally has
//               priority; after STARVE_LIMIT consecutive lost cycles L is
//               granted once. When both target the same non-zero register,
//               the older L result is written first so the younger P value
//               lands last. stall freezes the pipeline whenever P loses.
//               Optional build macro WB_ARB_STATS_EN adds saturating
//               conflict_cnt / force_cnt statistic outputs.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module wb_port_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             reset,        // asynchronous, active-low
  wb_port_arbiter_if.slave bus
`ifdef WB_ARB_STATS_EN
  ,
  output logic [31:0]      conflict_cnt,
  output logic [31:0]      force_cnt
`endif
);

  localparam int c_wait_w = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_wait_w-1:0] c_wait_max = c_wait_w'(STARVE_LIMIT);

  typedef enum logic [0:0] {
    S_NORM = 1'b0,   // P has priority
    S_FAIR = 1'b1    // L has priority for one grant
  } state_t;

  state_t              r_state;
  logic [c_wait_w-1:0] r_wait_cnt;
  logic                r_rf_we;
  logic [ADDR_W-1:0]   r_rw;
  logic [DATA_W-1:0]   r_wd;

  logic                w_both;
  logic                w_same_rd;
  logic                w_p_grant;
  logic                w_l_grant;
  logic [c_wait_w-1:0] w_wait_next;

  assign w_both    = bus.p_valid & bus.l_valid;
  // Same destination: the L result is older, so it must be written first.
  assign w_same_rd = w_both && (bus.p_rd == bus.l_rd) && (bus.l_rd != '0);

  // Grant selection: same-rd override, then state priority, then lone requester
  always_comb begin
    w_p_grant = 1'b0;
    w_l_grant = 1'b0;
    if (w_both) begin
      if (w_same_rd || (r_state == S_FAIR)) begin
        w_l_grant = 1'b1;
      end else begin
        w_p_grant = 1'b1;
      end
    end else if (bus.p_valid) begin
      w_p_grant = 1'b1;
    end else if (bus.l_valid) begin
      w_l_grant = 1'b1;
    end
  end

  // Starvation counter: counts consecutive cycles L waits, saturating
  always_comb begin
    w_wait_next = r_wait_cnt;
    if (!bus.l_valid || w_l_grant) begin
      w_wait_next = '0;
    end else if (r_wait_cnt != c_wait_max) begin
      w_wait_next = r_wait_cnt + 1'b1;
    end
  end

  assign bus.p_ready       = w_p_grant;
  assign bus.l_ready       = w_l_grant;
  assign bus.stall         = bus.p_valid & ~w_p_grant;
  assign bus.rf_we         = r_rf_we;
  assign bus.rw_out        = r_rw;
  assign bus.writedata_out = r_wd;

  // Priority FSM, starvation counter and registered write port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_NORM;
      r_wait_cnt <= '0;
      r_rf_we    <= 1'b0;
      r_rw       <= '0;
      r_wd       <= '0;
    end else begin
      r_wait_cnt <= w_wait_next;

      case (r_state)
        S_NORM: begin
          // The next-value compare lets L win on the cycle right after its
          // STARVE_LIMIT-th loss.
          if (w_wait_next == c_wait_max) begin
            r_state <= S_FAIR;
          end
        end
        S_FAIR: begin
          if (w_l_grant || !bus.l_valid) begin
            r_state <= S_NORM;
          end
        end
        default: r_state <= S_NORM;
      endcase

      // Writes to x0 still complete the handshake and move index/data,
      // but never assert the write enable.
      if (w_l_grant) begin
        r_rf_we <= (bus.l_rd != '0);
        r_rw    <= bus.l_rd;
        r_wd    <= bus.l_data;
      end else if (w_p_grant) begin
        r_rf_we <= (bus.p_rd != '0);
        r_rw    <= bus.p_rd;
        r_wd    <= bus.p_data;
      end else begin
        r_rf_we <= 1'b0;
      end
    end
  end

`ifdef WB_ARB_STATS_EN
  logic [31:0] r_conflict_cnt;
  logic [31:0] r_force_cnt;

  // Saturating statistics: contention cycles and FAIR-state grants
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_conflict_cnt <= '0;
      r_force_cnt    <= '0;
    end else begin
      if (w_both && (r_conflict_cnt != '1)) begin
        r_conflict_cnt <= r_conflict_cnt + 32'd1;
      end
      if ((r_state == S_FAIR) && (w_p_grant || w_l_grant) && (r_force_cnt != '1)) begin
        r_force_cnt <= r_force_cnt + 32'd1;
      end
    end
  end

  assign conflict_cnt = r_conflict_cnt;
  assign force_cnt    = r_force_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_wb_port_arbiter
// Description : Self-checking bench for wb_port_arbiter. Inputs are driven
//               1 time unit after posedge; readies are checked and expected
//               writes pushed to a scoreboard at negedge; the registered
//               write port is popped and compared at the following negedge.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_wb_port_arbiter;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  wr_t  sb[$];
  wr_t  e;

`ifdef WB_ARB_STATS_EN
  logic [31:0] conflict_cnt;
  logic [31:0] force_cnt;
`endif

  wb_port_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  wb_port_arbiter #(
    .DATA_W      (32),
    .ADDR_W      (5),
    .STARVE_LIMIT(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus)
`ifdef WB_ARB_STATS_EN
    ,
    .conflict_cnt(conflict_cnt),
    .force_cnt   (force_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic wr_t mk(input logic we, input logic [4:0] rd, input logic [31:0] d);
    wr_t w;
    w.we   = we;
    w.rd   = rd;
    w.data = d;
    return w;
  endfunction

  task automatic idle_inputs();
    bus.p_valid = 1'b0;
    bus.l_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    bus.p_valid = 1'b1; bus.p_rd = 5'd5; bus.p_data = 32'hAAAA5555;
    @(posedge clk); #3;
    checks++;
    if (bus.rf_we !== 1'b1) begin failures++; $display("FAIL reset_pre_we: got %b expected 1", bus.rf_we); end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL reset_we: got %b expected 0", bus.rf_we); end
    checks++;
    if (bus.rw_out !== 5'd0) begin failures++; $display("FAIL reset_rw: got %0d expected 0", bus.rw_out); end
    checks++;
    if (bus.writedata_out !== 32'd0) begin failures++; $display("FAIL reset_wd: got %h expected 0", bus.writedata_out); end
`ifdef WB_ARB_STATS_EN
    checks++;
    if (conflict_cnt !== 32'd0 || force_cnt !== 32'd0) begin
      failures++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", conflict_cnt, force_cnt);
    end
`endif
    idle_inputs();
    @(posedge clk); #1;
    @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL reset_no_replay: got %b expected 0", bus.rf_we); end
    // State must be NORM: P wins a plain conflict.
    bus.p_valid = 1'b1; bus.p_rd = 5'd3; bus.p_data = 32'h1;
    bus.l_valid = 1'b1; bus.l_rd = 5'd7; bus.l_data = 32'h2;
    @(negedge clk);
    checks++;
    if (bus.p_ready !== 1'b1 || bus.l_ready !== 1'b0) begin
      failures++; $display("FAIL reset_state_norm: got p_ready=%b l_ready=%b expected 1 0", bus.p_ready, bus.l_ready);
    end
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_single_p();
    @(negedge clk);
    checks++;
    if (bus.p_ready !== 1'b0 || bus.l_ready !== 1'b0 || bus.stall !== 1'b0) begin
      failures++; $display("FAIL idle_ready: got p=%b l=%b stall=%b expected 0 0 0", bus.p_ready, bus.l_ready, bus.stall);
    end
    @(posedge clk); #1;
    bus.p_valid = 1'b1; bus.p_rd = 5'd5; bus.p_data = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (bus.p_ready !== 1'b1 || bus.l_ready !== 1'b0 || bus.stall !== 1'b0) begin
      failures++; $display("FAIL single_p_ready: got p=%b l=%b stall=%b expected 1 0 0", bus.p_ready, bus.l_ready, bus.stall);
    end
    sb.push_back(mk(1'b1, 5'd5, 32'hDEADBEEF));
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (bus.rf_we !== e.we || bus.rw_out !== e.rd || bus.writedata_out !== e.data) begin
      failures++; $display("FAIL single_p_write: got %b/%0d/%h expected %b/%0d/%h",
                           bus.rf_we, bus.rw_out, bus.writedata_out, e.we, e.rd, e.data);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.rf_we !== 1'b0 || bus.rw_out !== 5'd5 || bus.writedata_out !== 32'hDEADBEEF) begin
      failures++; $display("FAIL no_grant_hold: got %b/%0d/%h expected 0/5/deadbeef",
                           bus.rf_we, bus.rw_out, bus.writedata_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_only_l();
    bus.l_valid = 1'b1; bus.l_rd = 5'd12; bus.l_data = 32'hCAFEF00D;
    @(negedge clk);
    checks++;
    if (bus.l_ready !== 1'b1 || bus.p_ready !== 1'b0 || bus.stall !== 1'b0) begin
      failures++; $display("FAIL only_l_ready: got l=%b p=%b stall=%b expected 1 0 0", bus.l_ready, bus.p_ready, bus.stall);
    end
    sb.push_back(mk(1'b1, 5'd12, 32'hCAFEF00D));
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (bus.rf_we !== e.we || bus.rw_out !== e.rd || bus.writedata_out !== e.data) begin
      failures++; $display("FAIL only_l_write: got %b/%0d/%h expected %b/%0d/%h",
                           bus.rf_we, bus.rw_out, bus.writedata_out, e.we, e.rd, e.data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_starvation();
    logic exp_l;
    bus.p_valid = 1'b1; bus.p_rd = 5'd3; bus.p_data = 32'h100;
    bus.l_valid = 1'b1; bus.l_rd = 5'd7; bus.l_data = 32'h200;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if (bus.rf_we !== e.we || bus.rw_out !== e.rd || bus.writedata_out !== e.data) begin
          failures++; $display("FAIL starve_write[%0d]: got %b/%0d/%h expected %b/%0d/%h",
                               i, bus.rf_we, bus.rw_out, bus.writedata_out, e.we, e.rd, e.data);
        end
      end
      exp_l = (i == 4);
      checks++;
      if (bus.p_ready !== !exp_l || bus.l_ready !== exp_l || bus.stall !== exp_l) begin
        failures++; $display("FAIL starve_grant[%0d]: got p=%b l=%b stall=%b expected %b %b %b",
                             i, bus.p_ready, bus.l_ready, bus.stall, !exp_l, exp_l, exp_l);
      end
      if (exp_l) sb.push_back(mk(1'b1, 5'd7, bus.l_data));
      else       sb.push_back(mk(1'b1, 5'd3, bus.p_data));
      @(posedge clk); #1;
      if (exp_l) bus.l_data = bus.l_data + 32'd1;
      else       bus.p_data = bus.p_data + 32'd1;
    end
    idle_inputs();
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (bus.rf_we !== e.we || bus.rw_out !== e.rd || bus.writedata_out !== e.data) begin
      failures++; $display("FAIL starve_write_last: got %b/%0d/%h expected %b/%0d/%h",
                           bus.rf_we, bus.rw_out, bus.writedata_out, e.we, e.rd, e.data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_same_rd();
    bus.p_valid = 1'b1; bus.p_rd = 5'd9; bus.p_data = 32'd2;
    bus.l_valid = 1'b1; bus.l_rd = 5'd9; bus.l_data = 32'd1;
    @(negedge clk);
    checks++;
    if (bus.l_ready !== 1'b1 || bus.p_ready !== 1'b0 || bus.stall !== 1'b1) begin
      failures++; $display("FAIL same_rd_first: got l=%b p=%b stall=%b expected 1 0 1", bus.l_ready, bus.p_ready, bus.stall);
    end
    sb.push_back(mk(1'b1, 5'd9, 32'd1));
    @(posedge clk); #1;
    bus.l_valid = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (bus.rf_we !== e.we || bus.rw_out !== e.rd || bus.writedata_out !== e.data) begin
      failures++; $display("FAIL same_rd_write1: got %b/%0d/%h expected %b/%0d/%h",
                           bus.rf_we, bus.rw_out, bus.writedata_out, e.we, e.rd, e.data);
    end
    checks++;
    if (bus.p_ready !== 1'b1 || bus.stall !== 1'b0) begin
      failures++; $display("FAIL same_rd_second: got p=%b stall=%b expected 1 0", bus.p_ready, bus.stall);
    end
    sb.push_back(mk(1'b1, 5'd9, 32'd2));
    @(posedge clk); #1;
    bus.p_valid = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (bus.rf_we !== e.we || bus.rw_out !== e.rd || bus.writedata_out !== e.data) begin
      failures++; $display("FAIL same_rd_write2: got %b/%0d/%h expected %b/%0d/%h",
                           bus.rf_we, bus.rw_out, bus.writedata_out, e.we, e.rd, e.data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_x0();
    bus.p_valid = 1'b1; bus.p_rd = 5'd0; bus.p_data = 32'h12345678;
    @(negedge clk);
    checks++;
    if (bus.p_ready !== 1'b1) begin failures++; $display("FAIL x0_ready: got %b expected 1", bus.p_ready); end
    sb.push_back(mk(1'b0, 5'd0, 32'h12345678));
    @(posedge clk); #1;
    // Both target x0: the same-rd override must not apply, so P wins.
    bus.p_data = 32'h11;
    bus.l_valid = 1'b1; bus.l_rd = 5'd0; bus.l_data = 32'h22;
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (bus.rf_we !== e.we || bus.rw_out !== e.rd || bus.writedata_out !== e.data) begin
      failures++; $display("FAIL x0_write: got %b/%0d/%h expected %b/%0d/%h",
                           bus.rf_we, bus.rw_out, bus.writedata_out, e.we, e.rd, e.data);
    end
    checks++;
    if (bus.p_ready !== 1'b1 || bus.l_ready !== 1'b0) begin
      failures++; $display("FAIL x0_both_grant: got p=%b l=%b expected 1 0", bus.p_ready, bus.l_ready);
    end
    sb.push_back(mk(1'b0, 5'd0, 32'h11));
    @(posedge clk); #1;
    bus.p_valid = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (bus.rf_we !== e.we || bus.rw_out !== e.rd || bus.writedata_out !== e.data) begin
      failures++; $display("FAIL x0_both_write: got %b/%0d/%h expected %b/%0d/%h",
                           bus.rf_we, bus.rw_out, bus.writedata_out, e.we, e.rd, e.data);
    end
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
  endtask

`ifdef WB_ARB_STATS_EN
  task automatic test_stats();
    reset = 1'b0;
    #1;
    checks++;
    if (conflict_cnt !== 32'd0 || force_cnt !== 32'd0) begin
      failures++; $display("FAIL stats_reset: got %0d/%0d expected 0/0", conflict_cnt, force_cnt);
    end
    @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;
    bus.p_valid = 1'b1; bus.p_rd = 5'd3; bus.p_data = 32'h5;
    bus.l_valid = 1'b1; bus.l_rd = 5'd7; bus.l_data = 32'h6;
    repeat (10) @(posedge clk);
    #1;
    idle_inputs();
    @(negedge clk);
    checks++;
    if (conflict_cnt !== 32'd10) begin failures++; $display("FAIL stats_conflict: got %0d expected 10", conflict_cnt); end
    checks++;
    if (force_cnt !== 32'd2) begin failures++; $display("FAIL stats_force: got %0d expected 2", force_cnt); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bus.p_valid = 1'b0; bus.p_rd = '0; bus.p_data = '0;
    bus.l_valid = 1'b0; bus.l_rd = '0; bus.l_data = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    test_reset();
    test_single_p();
    test_only_l();
    test_starvation();
    test_same_rd();
    test_x0();
`ifdef WB_ARB_STATS_EN
    test_stats();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
